gnr_attractor_ctrl: RTL and testbench

// - Upstream control stage of the GNR node array. Drives reset_nos, start_s0, start_s1 and the init vector

---
 rtl/gnr_pkg.sv | 16 +
 rtl/gnr_vec_eq.sv | 16 +
 rtl/gnr_attractor_ctrl.sv | 120 ++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnr_pkg.sv
// rtl/gnr_pkg.sv - shared state encoding and default sizes for the GNR attractor controller
package gnr_pkg;

    localparam int N_NODES_DEF   = 188;
    localparam int CNT_W_DEF     = 16;
    localparam int MAX_STEPS_DEF = 65535;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PERIOD,
        DONE
    } gnr_state_t;

endpackage

// File: rtl/gnr_vec_eq.sv
// rtl/gnr_vec_eq.sv - combinational equality of two node state vectors
module gnr_vec_eq #(
    parameter int W = 188
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    logic [W-1:0] diff;

    // Kept purely combinational: the controller evaluates hit/close in the same cycle as the vectors.
    assign diff = a ^ b;
    assign eq   = ~|diff;

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - Floyd cycle detection controller driving the GNR node array
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES   = N_NODES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic [N_NODES-1:0] init_data,
    output logic [N_NODES-1:0] init_vec,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    gnr_state_t       state;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] pc;
    logic             eq;
    logic             hit;
    logic             close;

    gnr_vec_eq #(
        .W (N_NODES)
    ) u_vec_eq (
        .a  (s0_vec),
        .b  (s1_vec),
        .eq (eq)
    );

    // The pass bit is only 1 at even hare counts, so only then is s0 the true x_(hc/2).
    assign hit   = (state == RUN) && eq && (hc != '0) && !hc[0];
    assign close = (state == PERIOD) && eq && (pc != '0);

    assign init_ready = (state == IDLE);
    assign start_s0   = (state == RUN) && !hit;
    assign start_s1   = ((state == RUN) && !hit) || ((state == PERIOD) && !close);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            init_vec    <= '0;
            reset_nos   <= 1'b0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            res_meet    <= '0;
            res_period  <= '0;
            hc          <= '0;
            pc          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_valid) begin
                        init_vec  <= init_data;
                        reset_nos <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    reset_nos   <= 1'b0;
                    hc          <= '0;
                    pc          <= '0;
                    res_timeout <= 1'b0;
                    res_meet    <= '0;
                    res_period  <= '0;
                    state       <= RUN;
                end
                RUN: begin
                    if (hit) begin
                        res_meet <= hc >> 1;
                        state    <= PERIOD;
                    end else if (hc == MAX_CNT) begin
                        res_timeout <= 1'b1;
                        res_period  <= '0;
                        res_meet    <= hc >> 1;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        hc <= hc + 1'b1;
                    end
                end
                PERIOD: begin
                    if (close) begin
                        res_period <= pc;
                        res_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (pc == MAX_CNT) begin
                        res_timeout <= 1'b1;
                        res_period  <= '0;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - directed and randomized checks of gnr_attractor_ctrl on a 4-node network
module tb_gnr_attractor_ctrl;

    localparam int NN = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    init_valid;
    logic [1:0]    init_ready;
    logic [NN-1:0] init_data [2];
    logic [NN-1:0] init_vec  [2];
    logic [1:0]    reset_nos;
    logic [1:0]    start_s0;
    logic [1:0]    start_s1;
    logic [NN-1:0] s0v [2];
    logic [NN-1:0] s1v [2];
    logic [1:0]    pass;
    logic [1:0]    res_valid;
    logic [1:0]    res_ready;
    logic [CW-1:0] res_meet   [2];
    logic [CW-1:0] res_period [2];
    logic [1:0]    res_timeout;

    logic [NN-1:0] tab [2][16];
    int            max_of [2];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(32)) u_dut0 (
        .clk (clk), .rst (rst),
        .init_valid (init_valid[0]), .init_ready (init_ready[0]),
        .init_data (init_data[0]), .init_vec (init_vec[0]),
        .reset_nos (reset_nos[0]), .start_s0 (start_s0[0]), .start_s1 (start_s1[0]),
        .s0_vec (s0v[0]), .s1_vec (s1v[0]),
        .res_valid (res_valid[0]), .res_ready (res_ready[0]),
        .res_meet (res_meet[0]), .res_period (res_period[0]), .res_timeout (res_timeout[0])
    );

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(8)) u_dut1 (
        .clk (clk), .rst (rst),
        .init_valid (init_valid[1]), .init_ready (init_ready[1]),
        .init_data (init_data[1]), .init_vec (init_vec[1]),
        .reset_nos (reset_nos[1]), .start_s0 (start_s0[1]), .start_s1 (start_s1[1]),
        .s0_vec (s0v[1]), .s1_vec (s1v[1]),
        .res_valid (res_valid[1]), .res_ready (res_ready[1]),
        .res_meet (res_meet[1]), .res_period (res_period[1]), .res_timeout (res_timeout[1])
    );

    // Behavioural node array: the hare steps every enable, the tortoise every other one via pass.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (reset_nos[u]) begin
                s0v[u]  <= init_vec[u];
                s1v[u]  <= init_vec[u];
                pass[u] <= 1'b1;
            end else begin
                if (start_s1[u]) s1v[u] <= tab[u][s1v[u]];
                if (start_s0[u]) begin
                    if (pass[u]) s0v[u] <= tab[u][s0v[u]];
                    pass[u] <= ~pass[u];
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                chk("nos_with_start", int'(reset_nos[u] && (start_s0[u] || start_s1[u])), 0);
                chk("s0_in_period", int'(start_s0[u] && !start_s1[u]), 0);
            end
        end
    end

    // Reference: iterate the state sequence and apply Floyd's definitions directly.
    function automatic void ref_model(input int u, input int x0, output int meet,
                                      output int period, output int to);
        int x [0:127];
        int k;
        int p;
        int mx;
        mx = max_of[u];
        x[0] = x0;
        for (int i = 1; i < 128; i++) x[i] = int'(tab[u][4'(x[i-1])]);
        meet = 0; period = 0; to = 0; k = 0; p = 0;
        for (int c = 1; 2 * c <= mx && k == 0; c++) if (x[c] == x[2*c]) k = c;
        if (k == 0) begin
            to = 1;
            meet = mx / 2;
        end else begin
            meet = k;
            for (int c = 1; c <= mx && p == 0; c++) if (x[k+c] == x[k]) p = c;
            if (p == 0) to = 1;
            else period = p;
        end
    endfunction

    task automatic set_rotate(input int u);
        for (int s = 0; s < 16; s++) begin
            logic [3:0] v;
            v = 4'(s);
            tab[u][s] = {v[2:0], v[3]};
        end
    endtask

    task automatic set_incr(input int u);
        for (int s = 0; s < 16; s++) tab[u][s] = 4'(s + 1);
    endtask

    task automatic do_init(input int u, input logic [3:0] x0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (init_ready[u]) ok = 1'b1;
            else @(negedge clk);
        end
        chk("init_ready_wait", int'(ok), 1);
        init_data[u]  = x0;
        init_valid[u] = 1'b1;
        @(negedge clk);
        init_valid[u] = 1'b0;
        chk("init_vec", int'(init_vec[u]), int'(x0));
        chk("busy_init_ready", int'(init_ready[u]), 0);
    endtask

    task automatic wait_res(input int u);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (res_valid[u]) ok = 1'b1;
            else @(negedge clk);
        end
        chk("res_valid_wait", int'(ok), 1);
    endtask

    task automatic check_res(input string tag, input int u, input int meet, input int period, input int to);
        chk({tag, "_meet"}, int'(res_meet[u]), meet);
        chk({tag, "_period"}, int'(res_period[u]), period);
        chk({tag, "_timeout"}, int'(res_timeout[u]), to);
    endtask

    task automatic handshake(input int u);
        res_ready[u] = 1'b1;
        @(negedge clk);
        res_ready[u] = 1'b0;
        chk("res_valid_drop", int'(res_valid[u]), 0);
        chk("idle_init_ready", int'(init_ready[u]), 1);
    endtask

    initial begin
        int em, ep, et;
        bit ok;
        rst        = 1'b1;
        init_valid = '0;
        res_ready  = '0;
        for (int u = 0; u < 2; u++) init_data[u] = '0;
        max_of[0] = 32;
        max_of[1] = 8;
        set_rotate(0);
        set_incr(1);
        repeat (3) @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            chk("rst_init_ready", int'(init_ready[u]), 1);
            chk("rst_strobes", int'({reset_nos[u], start_s0[u], start_s1[u]}), 0);
            chk("rst_res_valid", int'(res_valid[u]), 0);
            chk("rst_init_vec", int'(init_vec[u]), 0);
            check_res("rst", u, 0, 0, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        do_init(0, 4'b0001);
        wait_res(0);
        check_res("rot0001", 0, 4, 4, 0);
        handshake(0);

        do_init(0, 4'b0000);
        wait_res(0);
        check_res("rot0000", 0, 1, 1, 0);
        handshake(0);

        do_init(1, 4'b0000);
        wait_res(1);
        check_res("incr_timeout", 1, 4, 0, 1);
        handshake(1);

        // Back-pressure with a competing init offered the whole time.
        do_init(0, 4'b0001);
        wait_res(0);
        init_data[0]  = 4'b0000;
        init_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_res("bp_hold", 0, 4, 4, 0);
            chk("bp_res_valid", int'(res_valid[0]), 1);
            chk("bp_init_ready", int'(init_ready[0]), 0);
            chk("bp_init_vec", int'(init_vec[0]), 1);
            @(negedge clk);
        end
        res_ready[0] = 1'b1;
        @(negedge clk);
        res_ready[0] = 1'b0;
        chk("bp_after_hs_ready", int'(init_ready[0]), 1);
        chk("bp_after_hs_valid", int'(res_valid[0]), 0);
        @(negedge clk);
        init_valid[0] = 1'b0;
        chk("bp_second_accept", int'(init_ready[0]), 0);
        chk("bp_second_vec", int'(init_vec[0]), 0);
        wait_res(0);
        check_res("bp_second", 0, 1, 1, 0);
        handshake(0);

        // Reset while the hare is measuring the period.
        do_init(0, 4'b0001);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (start_s1[0] && !start_s0[0]) ok = 1'b1;
            else @(negedge clk);
        end
        chk("period_reached", int'(ok), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_init_ready", int'(init_ready[0]), 1);
        chk("mid_rst_strobes", int'({reset_nos[0], start_s0[0], start_s1[0]}), 0);
        chk("mid_rst_res_valid", int'(res_valid[0]), 0);
        do_init(0, 4'b0001);
        wait_res(0);
        check_res("rerun", 0, 4, 4, 0);
        handshake(0);

        for (int it = 0; it < 24; it++) begin
            int u;
            logic [3:0] x0;
            u = int'($urandom_range(0, 1));
            for (int s = 0; s < 16; s++) tab[u][s] = 4'($urandom_range(0, 15));
            x0 = 4'($urandom_range(0, 15));
            ref_model(u, int'(x0), em, ep, et);
            do_init(u, x0);
            wait_res(u);
            check_res("rand", u, em, ep, et);
            handshake(u);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
